// File: rtl/product_accumulator.sv
// Saturating batch accumulator for 4-bit multiplier products with a valid/ready result port.
// Define PRODUCT_ACC_OVERLAP_EN to let the next batch accumulate while a result waits.
module product_accumulator #(
  parameter int ACC_WIDTH = 8,
  parameter int TERMS     = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 P0,
  input  logic                 P1,
  input  logic                 P2,
  input  logic                 P3,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic                 Clr,
  output logic [ACC_WIDTH-1:0] Result,
  output logic                 OOvf,
  output logic                 OValid,
  input  logic                 OReady
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [3:0] LAST_CNT = 4'(TERMS - 1);

  state_t               state_r, state_s;
  logic [ACC_WIDTH-1:0] acc_r, acc_s;
  logic [3:0]           count_r, count_s;
  logic                 ovf_r, ovf_s;
  logic [ACC_WIDTH-1:0] result_r, result_s;
  logic                 oovf_r, oovf_s;
  logic                 ovalid_r, ovalid_s;

  logic [ACC_WIDTH:0]   prod_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 sat_s;
  logic [ACC_WIDTH-1:0] clamped_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic                 last_s;

  // Operand widening, saturating add and input handshake decode
  always_comb begin
    prod_s    = {{(ACC_WIDTH-3){1'b0}}, P3, P2, P1, P0};
    sum_s     = {1'b0, acc_r} + prod_s;
    sat_s     = sum_s[ACC_WIDTH];
    clamped_s = sat_s ? {ACC_WIDTH{1'b1}} : sum_s[ACC_WIDTH-1:0];
    last_s    = (count_r == LAST_CNT);
`ifdef PRODUCT_ACC_OVERLAP_EN
    // Only the final term of a batch must wait for the holding register to drain.
    in_ready_s = !(last_s && ovalid_r && !OReady);
`else
    in_ready_s = (state_r == ACCUM);
`endif
    accept_s  = InValid && in_ready_s;
  end

  // Next-state and next-output computation
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    count_s  = count_r;
    ovf_s    = ovf_r;
    result_s = result_r;
    oovf_s   = oovf_r;
    ovalid_s = ovalid_r;
`ifdef PRODUCT_ACC_OVERLAP_EN
    if (ovalid_r && OReady) begin
      ovalid_s = 1'b0;
    end else begin
      ovalid_s = ovalid_r;
    end
    if (Clr) begin
      acc_s   = {ACC_WIDTH{1'b0}};
      count_s = 4'd0;
      ovf_s   = 1'b0;
    end else if (accept_s) begin
      if (last_s) begin
        result_s = clamped_s;
        oovf_s   = ovf_r | sat_s;
        ovalid_s = 1'b1;
        acc_s    = {ACC_WIDTH{1'b0}};
        count_s  = 4'd0;
        ovf_s    = 1'b0;
      end else begin
        acc_s   = clamped_s;
        count_s = count_r + 4'd1;
        ovf_s   = ovf_r | sat_s;
      end
    end else begin
      acc_s = acc_r;
    end
    state_s = ovalid_s ? HOLD : ACCUM;
`else
    case (state_r)
      ACCUM: begin
        if (Clr) begin
          acc_s   = {ACC_WIDTH{1'b0}};
          count_s = 4'd0;
          ovf_s   = 1'b0;
        end else if (accept_s) begin
          if (last_s) begin
            result_s = clamped_s;
            oovf_s   = ovf_r | sat_s;
            ovalid_s = 1'b1;
            acc_s    = {ACC_WIDTH{1'b0}};
            count_s  = 4'd0;
            ovf_s    = 1'b0;
            state_s  = HOLD;
          end else begin
            acc_s   = clamped_s;
            count_s = count_r + 4'd1;
            ovf_s   = ovf_r | sat_s;
          end
        end else begin
          acc_s = acc_r;
        end
      end
      HOLD: begin
        if (OReady) begin
          ovalid_s = 1'b0;
          state_s  = ACCUM;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s  = ACCUM;
        ovalid_s = 1'b0;
      end
    endcase
`endif
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= ACCUM;
      acc_r    <= {ACC_WIDTH{1'b0}};
      count_r  <= 4'd0;
      ovf_r    <= 1'b0;
      result_r <= {ACC_WIDTH{1'b0}};
      oovf_r   <= 1'b0;
      ovalid_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      count_r  <= count_s;
      ovf_r    <= ovf_s;
      result_r <= result_s;
      oovf_r   <= oovf_s;
      ovalid_r <= ovalid_s;
    end
  end

  assign InReady = in_ready_s;
  assign Result  = result_r;
  assign OOvf    = oovf_r;
  assign OValid  = ovalid_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed scoreboard bench for product_accumulator: an 8-bit and a 5-bit instance share stimulus.
module tb_product_accumulator;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] p;
  logic       InValid, Clr, OReady;

  logic       in_ready8, oovf8, ovalid8;
  logic [7:0] result8;
  logic       in_ready5, oovf5, ovalid5;
  logic [4:0] result5;

  always #5 CLK = ~CLK;

  product_accumulator #(.ACC_WIDTH(8), .TERMS(4)) dut (
    .CLK(CLK), .RST(RST), .P0(p[0]), .P1(p[1]), .P2(p[2]), .P3(p[3]),
    .InValid(InValid), .InReady(in_ready8), .Clr(Clr),
    .Result(result8), .OOvf(oovf8), .OValid(ovalid8), .OReady(OReady)
  );

  product_accumulator #(.ACC_WIDTH(5), .TERMS(4)) dut5 (
    .CLK(CLK), .RST(RST), .P0(p[0]), .P1(p[1]), .P2(p[2]), .P3(p[3]),
    .InValid(InValid), .InReady(in_ready5), .Clr(Clr),
    .Result(result5), .OOvf(oovf5), .OValid(ovalid5), .OReady(OReady)
  );

  typedef struct packed {
    logic [7:0] r8;
    logic       o8;
    logic [4:0] r5;
    logic       o5;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  int   m_acc8, m_acc5, m_cnt;
  logic m_ov8, m_ov5, m_hold, m_zero;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc8 = 0; m_acc5 = 0; m_cnt = 0;
    m_ov8 = 1'b0; m_ov5 = 1'b0; m_hold = 1'b0; m_zero = 1'b1;
    q.delete();
  endtask

  // Compare DUT outputs against the model state reached after the last edge.
  task automatic check();
    chk("inready8", {15'd0, in_ready8}, {15'd0, !m_hold});
    chk("ovalid8",  {15'd0, ovalid8},   {15'd0, m_hold});
    chk("inready5", {15'd0, in_ready5}, {15'd0, !m_hold});
    chk("ovalid5",  {15'd0, ovalid5},   {15'd0, m_hold});
    if (m_zero) begin
      chk("rst_result8", {8'd0, result8}, 16'd0);
      chk("rst_oovf8",   {15'd0, oovf8},  16'd0);
      chk("rst_result5", {11'd0, result5}, 16'd0);
      chk("rst_oovf5",   {15'd0, oovf5},  16'd0);
    end
    if (m_hold) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 16'd1, 16'd0);
      end else begin
        chk("result8", {8'd0, result8},  {8'd0, q[0].r8});
        chk("oovf8",   {15'd0, oovf8},   {15'd0, q[0].o8});
        chk("result5", {11'd0, result5}, {11'd0, q[0].r5});
        chk("oovf5",   {15'd0, oovf5},   {15'd0, q[0].o5});
      end
    end
  endtask

  // One clock cycle: check, drive inputs, and advance the model to the next edge.
  task automatic tick(input logic rst, input logic v, input logic [3:0] pv,
                      input logic clr, input logic rdy);
    int a8, a5;
    exp_t e;
    @(negedge CLK);
    check();
    RST = rst; InValid = v; p = pv; Clr = clr; OReady = rdy;
    if (rst) begin
      model_reset();
    end else if (m_hold) begin
      if (rdy) begin
        void'(q.pop_front());
        m_hold = 1'b0;
      end
    end else if (clr) begin
      m_acc8 = 0; m_acc5 = 0; m_cnt = 0; m_ov8 = 1'b0; m_ov5 = 1'b0;
    end else if (v) begin
      a8 = m_acc8 + int'(pv);
      a5 = m_acc5 + int'(pv);
      if (a8 > 255) begin a8 = 255; m_ov8 = 1'b1; end
      if (a5 > 31)  begin a5 = 31;  m_ov5 = 1'b1; end
      if (m_cnt == 3) begin
        e.r8 = 8'(a8); e.o8 = m_ov8; e.r5 = 5'(a5); e.o5 = m_ov5;
        q.push_back(e);
        m_acc8 = 0; m_acc5 = 0; m_cnt = 0; m_ov8 = 1'b0; m_ov5 = 1'b0;
        m_hold = 1'b1;
        m_zero = 1'b0;
      end else begin
        m_acc8 = a8; m_acc5 = a5; m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic feed(input logic [3:0] pv);
    tick(1'b0, 1'b1, pv, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, 1'b0, 4'd0, 1'b0, rdy);
  endtask

  initial begin
    RST = 1'b1; InValid = 1'b0; p = 4'd0; Clr = 1'b0; OReady = 1'b0;
    model_reset();
    @(posedge CLK);

    // Basic sum 9*4 = 36; the 5-bit instance saturates to 31.
    feed(4'd9); feed(4'd9); feed(4'd9); feed(4'd9);
    idle(1'b1); idle(1'b1);

    // Unsaturated batch after a saturated one.
    feed(4'd1); feed(4'd1); feed(4'd1); feed(4'd1);
    idle(1'b1); idle(1'b1);

    // Backpressure: products offered and Clr asserted while held are ignored.
    feed(4'd2); feed(4'd3); feed(4'd0); feed(4'd1);
    tick(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1); idle(1'b1);

    // Clr beats a simultaneous product; partial batch is discarded.
    feed(4'd6); feed(4'd4);
    tick(1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
    feed(4'd1); feed(4'd1); feed(4'd1); feed(4'd1);
    idle(1'b1); idle(1'b1);

    // Gaps between products do not disturb the count.
    feed(4'd15); idle(1'b1); feed(4'd15); idle(1'b1); feed(4'd15); feed(4'd15);
    idle(1'b1); idle(1'b1);

    // Reset mid-batch, then a fresh batch of 2s.
    feed(4'd9); feed(4'd9); feed(4'd9);
    tick(1'b1, 1'b1, 4'd9, 1'b0, 1'b1);
    feed(4'd2); feed(4'd2); feed(4'd2); feed(4'd2);
    idle(1'b0);

    // Reset while a result is held.
    tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(1'b1); idle(1'b1);

    chk("scoreboard_drained", 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 2-bit multiplier. Consumes its 4-bit product, presented as individual bits P0..P3, one product per valid strobe.
- Sums a fixed batch of TERMS products into a saturating ACC_WIDTH-bit accumulator.
- Presents each batch result on a valid/ready output handshake for the display/readout logic.

Parameters:
- ACC_WIDTH, 8, accumulator and result width in bits; legal range 4..16.
- TERMS, 4, products per batch; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- P0  input  1  product bit 0 (LSB), driven by multiplier S0.
- P1  input  1  product bit 1, driven by multiplier S1.
- P2  input  1  product bit 2, driven by multiplier S2.
- P3  input  1  product bit 3 (MSB), driven by multiplier S3.
- InValid  input  1  P0..P3 hold a product this cycle.
- InReady  output  1  block accepts a product this cycle.
- Clr  input  1  synchronous abort of the partial batch.
- Result  output  ACC_WIDTH  batch sum; held stable while OValid=1.
- OOvf  output  1  batch saturated; qualified by OValid.
- OValid  output  1  Result/OOvf are valid.
- OReady  input  1  consumer takes Result this cycle.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous, active-high.
- Product operand: {P3,P2,P1,P0}, zero-extended to ACC_WIDTH+1 bits for the add.
- Accept rule: a product is accepted when InValid=1 and InReady=1 on a rising edge.
- Reset: when RST=1 at an edge:
  - Result=0, OOvf=0, OValid=0.
  - acc=0, count=0, ovf=0, state=ACCUM.
  - InReady=1 from the first cycle after reset.
  - RST overrides Clr, InValid and OReady.
- State ACCUM:
  - InReady=1, OValid=0.
  - On accept, compute sum = acc + product.
  - If sum > 2^ACC_WIDTH-1, clamp to 2^ACC_WIDTH-1 and set ovf; ovf is sticky for the batch.
  - If count < TERMS-1: acc <= sum, count <= count+1.
  - If count = TERMS-1:
    - Result <= sum (clamped), OOvf <= ovf including this term, OValid <= 1.
    - acc, count and ovf cleared; go to HOLD.
  - Latency: OValid rises on the edge that accepts the last term, so it is visible the cycle after.
- State HOLD:
  - InReady=0; Result and OOvf remain stable.
  - On OValid=1 and OReady=1: OValid <= 0, go to ACCUM. InReady=1 the following cycle.
- Clr:
  - In ACCUM: clears acc, count and ovf. Clr beats an InValid in the same cycle; that product is dropped.
  - In HOLD: ignored.
- TERMS=1: every accepted product is itself a result.
- InValid with InReady=0: no effect; no internal buffering of the input.
- Result is registered; there is no combinational path from P0..P3 to Result.

Optional Feature:
- Macro: PRODUCT_ACC_OVERLAP_EN.
- Defined:
  - Result, OOvf and OValid form a separate holding register.
  - InReady stays 1 during HOLD, so the next batch accumulates while the previous result waits.
  - InReady drops to 0 only when count = TERMS-1 and OValid=1 with OReady=0. This stalls the last term until the result drains.
  - If OReady=1 in the same cycle the last term is accepted, the old result is taken and the new one is loaded with OValid kept at 1.
  - Clr then aborts only the accumulating batch, never the held result.
- Undefined:
  - Strict ACCUM/HOLD alternation as described above.
  - Throughput is at most one batch per TERMS+1 cycles.

Test Plan:
- Basic sum: RST for 1 cycle, then 4 back-to-back products of 9 (P3..P0=1001), OReady=1. Required: OValid=1 for exactly 1 cycle with Result=36, OOvf=0, InReady=0 during that cycle.
- Saturation: ACC_WIDTH=5, products 9,9,9,9. Required: Result=31, OOvf=1. Next batch 1,1,1,1 gives Result=4, OOvf=0.
- Backpressure: complete a batch with products 2,3,0,1 and hold OReady=0 for 3 cycles. Required: Result=6 stable, OValid=1, InReady=0 for all 3 cycles. OReady=1 then drops OValid on the next edge.
- Clr mid-batch: accept 6 and 4, assert Clr together with InValid (product 9), then feed 1,1,1,1. Required: Result=4.
- Reset mid-batch: accept 3 products of 9, assert RST. Required: all outputs 0 the next cycle. Then feed 2,2,2,2, giving Result=8.
- Overlap (PRODUCT_ACC_OVERLAP_EN): OReady=0, feed 8 continuous products of 1. Required: InReady=1 until the 8th product is pending, stalled at 0 until OReady=1. Result sequence 4 then 4.
